// File: rtl/counter.sv
// Saturating up/down counter (0..MAX_VAL) driven by two asynchronous event inputs.
// Each event input is synchronized into clk_i and rising-edge detected before counting.
module counter #(
  parameter int unsigned BW          = 7,
  parameter int unsigned MAX_VAL     = 99,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clk_up_i,
  input  logic          clk_down_i,
  output logic [BW-1:0] counter_val_o
);

  localparam logic [BW-1:0] LP_MAX = BW'(MAX_VAL);

  logic [SYNC_STAGES-1:0] r_sync_up;
  logic [SYNC_STAGES-1:0] r_sync_dn;
  logic                   r_hist_up;
  logic                   r_hist_dn;
  logic [BW-1:0]          r_count;

  logic                   w_up_pulse;
  logic                   w_dn_pulse;
  logic [BW-1:0]          w_count_nxt;

  // Synchronizer chains plus one history flop per input; reset clears all of them
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync_up <= '0;
      r_sync_dn <= '0;
      r_hist_up <= 1'b0;
      r_hist_dn <= 1'b0;
    end else begin
      r_sync_up <= {r_sync_up[SYNC_STAGES-2:0], clk_up_i};
      r_sync_dn <= {r_sync_dn[SYNC_STAGES-2:0], clk_down_i};
      r_hist_up <= r_sync_up[SYNC_STAGES-1];
      r_hist_dn <= r_sync_dn[SYNC_STAGES-1];
    end
  end

  assign w_up_pulse = r_sync_up[SYNC_STAGES-1] & ~r_hist_up;
  assign w_dn_pulse = r_sync_dn[SYNC_STAGES-1] & ~r_hist_dn;

  // Saturating next count; coincident up and down pulses cancel
  always_comb begin
    w_count_nxt = r_count;
    case ({w_up_pulse, w_dn_pulse})
      2'b10: begin
        if (r_count < LP_MAX) begin
          w_count_nxt = r_count + BW'(1);
        end
      end
      2'b01: begin
        if (r_count != '0) begin
          w_count_nxt = r_count - BW'(1);
        end
      end
      default: begin
        w_count_nxt = r_count;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign counter_val_o = r_count;

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: expected counts are queued with their due cycle
// when events are driven, and compared against counter_val_o every cycle.
module tb_counter;

  localparam int unsigned BW  = 7;
  localparam int          MAX = 99;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          clk_up_i = 1'b0;
  logic          clk_down_i = 1'b0;
  logic [BW-1:0] counter_val_o;

  counter #(
    .BW         (BW),
    .MAX_VAL    (MAX),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clk_up_i     (clk_up_i),
    .clk_down_i   (clk_down_i),
    .counter_val_o(counter_val_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int due;
    int val;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   m       = 0;
  int   exp_cur = 0;
  bit   chk_en  = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Retire expectations when due, then compare the live output every cycle
  always @(negedge clk_i) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_cur = q[0].val;
      chk_en  = 1'b1;
      void'(q.pop_front());
    end
    if (chk_en) check("val", int'(counter_val_o), exp_cur);
  end

  function automatic void push(input int due, input int val);
    exp_t e;
    e.due = due;
    e.val = val;
    q.push_back(e);
  endfunction

  function automatic void model_step(input bit up, input bit dn);
    if (up && !dn && m < MAX) m++;
    else if (dn && !up && m > 0) m--;
  endfunction

  task automatic apply_reset(input int n);
    @(negedge clk_i);
    rst_i = 1'b1;
    m = 0;
    push(cyc + 1, 0);
    repeat (n) @(negedge clk_i);
    rst_i = 1'b0;
    if (clk_up_i || clk_down_i) begin
      model_step(clk_up_i, clk_down_i);
      push(cyc + 3, m);
    end
  endtask

  task automatic pulse(input bit up, input bit dn);
    @(negedge clk_i);
    clk_up_i   = up;
    clk_down_i = dn;
    model_step(up, dn);
    push(cyc + 3, m);
    repeat (4) @(negedge clk_i);
    clk_up_i   = 1'b0;
    clk_down_i = 1'b0;
    repeat (4) @(negedge clk_i);
  endtask

  task automatic pulses(input bit up, input bit dn, input int n);
    for (int i = 0; i < n; i++) pulse(up, dn);
  endtask

  initial begin
    // Up ramp 0..50
    apply_reset(3);
    pulses(1'b1, 1'b0, 50);
    check("ramp50", int'(counter_val_o), 50);

    // Upper saturation, then one step down
    apply_reset(3);
    pulses(1'b1, 1'b0, 120);
    check("sat99", int'(counter_val_o), 99);
    pulse(1'b0, 1'b1);
    check("dn98", int'(counter_val_o), 98);

    // Down to zero and hold
    apply_reset(2);
    pulses(1'b1, 1'b0, 5);
    pulses(1'b0, 1'b1, 10);
    check("sat0", int'(counter_val_o), 0);

    // Simultaneous events at 0, 42 and 99; staggered at 42
    pulse(1'b1, 1'b1);
    pulses(1'b1, 1'b0, 42);
    pulse(1'b1, 1'b1);
    check("both42", int'(counter_val_o), 42);
    @(negedge clk_i);
    clk_up_i = 1'b1;
    model_step(1'b1, 1'b0);
    push(cyc + 3, m);
    repeat (3) @(negedge clk_i);
    clk_down_i = 1'b1;
    model_step(1'b0, 1'b1);
    push(cyc + 3, m);
    repeat (4) @(negedge clk_i);
    clk_up_i   = 1'b0;
    clk_down_i = 1'b0;
    repeat (4) @(negedge clk_i);
    pulses(1'b1, 1'b0, 57);
    pulse(1'b1, 1'b1);
    check("both99", int'(counter_val_o), 99);

    // Held-high input counts once
    apply_reset(2);
    pulses(1'b1, 1'b0, 10);
    @(negedge clk_i);
    clk_up_i = 1'b1;
    model_step(1'b1, 1'b0);
    push(cyc + 3, m);
    repeat (100) @(negedge clk_i);
    clk_up_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("held11", int'(counter_val_o), 11);

    // Input high across reset release: 0 then 1
    @(negedge clk_i);
    rst_i = 1'b1;
    m = 0;
    push(cyc + 1, 0);
    @(negedge clk_i);
    clk_up_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    model_step(1'b1, 1'b0);
    push(cyc + 3, m);
    repeat (6) @(negedge clk_i);
    clk_up_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("rel1", int'(counter_val_o), 1);

    // Reset at 77 while the up input rises on the reset edge
    apply_reset(2);
    pulses(1'b1, 1'b0, 77);
    check("pre77", int'(counter_val_o), 77);
    @(negedge clk_i);
    clk_up_i = 1'b1;
    rst_i    = 1'b1;
    m = 0;
    push(cyc + 1, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_step(1'b1, 1'b0);
    push(cyc + 3, m);
    repeat (4) @(negedge clk_i);
    clk_up_i = 1'b0;
    repeat (4) @(negedge clk_i);
    pulse(1'b1, 1'b0);
    check("resume2", int'(counter_val_o), 2);

    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk_i);
    check("drain", q.size(), 0);
    repeat (5) @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
